dpi_stream_sequencer: RTL

Upstream feeder for the per-regex matcher wrappers in the kraaken DPI core. Accepts packet bytes tagged with a 16-bit flow tag and maps each flow to a 6-bit stream ID using a 64-entry flow table. Drives the matchers' shared control bus with a fixed sequence per packet: state load, character stream, EOP. The sequence timing respects the matchers' internal register stages.

---
 rtl/dpi_pkg.sv | 20 ++
 rtl/dpi_flow_table.sv | 56 +++++
 rtl/dpi_stream_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/dpi_pkg.sv
// Shared definitions for the DPI stream sequencer: ID/tag widths, flow table
// depth and the per-packet sequencing states.
package dpi_pkg;

  localparam int STREAM_ID_W = 6;
  localparam int FLOW_W      = 16;
  localparam int N_STREAMS   = 64;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    LOAD,
    GAP,
    STREAM,
    DRAIN,
    EOPS,
    DISCARD
  } seq_state_e;

endpackage

// File: rtl/dpi_flow_table.sv
// Flow-tag to stream-ID map. 64 entries of {valid, tag}, all compared in
// parallel against the tag. On a miss, the lowest free entry is offered on
// index, and alloc claims it. Entries are only freed by reset.
//   clk, rst  : clock, async active-high reset (clears all valid bits)
//   tag       : flow tag to look up / allocate
//   alloc     : claim entry `index` for `tag` (ignored when full)
//   hit       : tag found in a valid entry
//   full      : every entry valid
//   index     : hit ? matching entry : lowest free entry
module dpi_flow_table
  import dpi_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FLOW_W-1:0]      tag,
  input  logic                   alloc,
  output logic                   hit,
  output logic                   full,
  output logic [STREAM_ID_W-1:0] index
);

  logic [N_STREAMS-1:0]   valid;
  logic [FLOW_W-1:0]      tags [N_STREAMS];
  logic [N_STREAMS-1:0]   match;
  logic [STREAM_ID_W-1:0] hit_idx;
  logic [STREAM_ID_W-1:0] free_idx;

  for (genvar g = 0; g < N_STREAMS; g++) begin : g_cmp
    assign match[g] = valid[g] && (tags[g] == tag);
  end

  // Scan high to low so the lowest index wins.
  always_comb begin
    hit_idx  = '0;
    free_idx = '0;
    for (int i = N_STREAMS - 1; i >= 0; i--) begin
      if (match[i]) hit_idx = STREAM_ID_W'(i);
      if (!valid[i]) free_idx = STREAM_ID_W'(i);
    end
  end

  assign hit   = |match;
  assign full  = &valid;
  assign index = hit ? hit_idx : free_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid <= '0;
    else if (alloc && !full) valid[free_idx] <= 1'b1;
  end

  // Tag storage needs no reset; valid gates every compare.
  always_ff @(posedge clk) begin
    if (alloc && !full) tags[free_idx] <= tag;
  end

endmodule

// File: rtl/dpi_stream_sequencer.sv
// Upstream feeder for the per-regex matchers. Maps each packet's flow tag to
// a stream ID and drives the matchers' control bus with
//   load_state -> (LOAD_GAP) -> char stream -> (DRAIN) -> eop.
// Packets whose flow cannot be allocated (table full) are swallowed and
// counted in drop_cnt.
//   pkt_*            : byte stream in, pkt_rdy handshake, flow on SOP beat
//   cfg_*            : per-stream engine enable table write port
//   char_in/_vld     : registered bytes to matchers
//   stream_id, new_stream_id, enable : held from load_state through eop
//   load_state, eop  : one-cycle sequence pulses
//   drop_cnt         : saturating count of discarded packets
module dpi_stream_sequencer
  import dpi_pkg::*;
#(
  parameter int N_ENGINES = 8,
  parameter int LOAD_GAP  = 3,
  parameter int DRAIN     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             pkt_data,
  input  logic                   pkt_vld,
  input  logic                   pkt_sop,
  input  logic                   pkt_eop,
  input  logic [FLOW_W-1:0]      pkt_flow,
  output logic                   pkt_rdy,
  input  logic                   cfg_we,
  input  logic [STREAM_ID_W-1:0] cfg_stream_id,
  input  logic [N_ENGINES-1:0]   cfg_enable,
  output logic [7:0]             char_in,
  output logic                   char_in_vld,
  output logic [STREAM_ID_W-1:0] stream_id,
  output logic                   new_stream_id,
  output logic                   load_state,
  output logic                   eop,
  output logic [N_ENGINES-1:0]   enable,
  output logic [15:0]            drop_cnt
);

  seq_state_e             state, state_nx;
  logic [7:0]             cnt;
  logic [FLOW_W-1:0]      flow_r;
  logic                   ft_hit, ft_full, ft_alloc;
  logic [STREAM_ID_W-1:0] ft_index;
  logic [N_ENGINES-1:0]   en_tab [N_STREAMS];
  logic [N_ENGINES-1:0]   enable_r;
  logic                   accept;

  dpi_flow_table u_flow_table (
    .clk   (clk),
    .rst   (rst),
    .tag   (flow_r),
    .alloc (ft_alloc),
    .hit   (ft_hit),
    .full  (ft_full),
    .index (ft_index)
  );

  assign accept = (state == STREAM) && pkt_vld;

  // The DRAIN parameter shadows the imported state literal, so the state is
  // named through the package scope.
  always_comb begin
    state_nx   = state;
    pkt_rdy    = 1'b0;
    load_state = 1'b0;
    eop        = 1'b0;
    ft_alloc   = 1'b0;
    case (state)
      IDLE:   if (pkt_vld && pkt_sop) state_nx = LOOKUP;
      LOOKUP: begin
        if (ft_hit) state_nx = LOAD;
        else if (!ft_full) begin
          ft_alloc = 1'b1;
          state_nx = LOAD;
        end else state_nx = DISCARD;
      end
      LOAD: begin
        load_state = 1'b1;
        state_nx   = GAP;
      end
      // LOAD plus GAP span LOAD_GAP-1 cycles; the byte accepted in the first
      // STREAM cycle then lands on char_in exactly LOAD_GAP after load_state.
      GAP:    if (cnt == 8'(LOAD_GAP - 3)) state_nx = STREAM;
      STREAM: begin
        pkt_rdy = 1'b1;
        if (pkt_vld && pkt_eop) state_nx = dpi_pkg::DRAIN;
      end
      // Entered on the cycle of the last char_in_vld.
      dpi_pkg::DRAIN: if (cnt == 8'(DRAIN - 1)) state_nx = EOPS;
      EOPS: begin
        eop      = 1'b1;
        state_nx = IDLE;
      end
      DISCARD: begin
        pkt_rdy = 1'b1;
        if (pkt_vld && pkt_eop) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state_nx != state) ? 8'd0 : cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flow_r        <= '0;
      stream_id     <= '0;
      new_stream_id <= 1'b0;
      enable_r      <= '0;
      char_in       <= '0;
      char_in_vld   <= 1'b0;
      drop_cnt      <= '0;
    end else begin
      char_in_vld <= accept;
      if (accept) char_in <= pkt_data;
      if (state == IDLE && pkt_vld && pkt_sop) flow_r <= pkt_flow;
      if (state == LOOKUP && (ft_hit || !ft_full)) begin
        stream_id     <= ft_index;
        new_stream_id <= !ft_hit;
      end
      // Snapshot so cfg writes during the packet do not disturb it.
      if (state == LOAD) enable_r <= en_tab[stream_id];
      if (state == LOOKUP && !ft_hit && ft_full && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_STREAMS; i++) en_tab[i] <= '0;
    end else if (cfg_we) begin
      en_tab[cfg_stream_id] <= cfg_enable;
    end
  end

  assign enable = (state == LOAD) ? en_tab[stream_id] : enable_r;

endmodule
